vend_dispense_ctrl: RTL and testbench

- Consumer side of the vending FSM outputs (S = serve, R = return change).
- Converts a one-cycle vend request into timed actuator drive:
  - product motor on-time;
  - drop-sensor confirmation with timeout;
  - N nickel-return solenoid pulses.
- Sits between the vending FSM and the board actuator/sensor pins. Reports busy, done and fault status back to the top level.

---
 rtl/vend_pkg.sv | 23 ++
 rtl/sync_edge_det.sv | 29 ++
 rtl/vend_dispense_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared encodings for the vending dispense path: controller states, coin values
// and the vending-FSM "R" output to nickel-count mapping.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MOTOR      = 3'd1,
    WAIT_DROP  = 3'd2,
    CHANGE_ON  = 3'd3,
    CHANGE_GAP = 3'd4,
    DONE       = 3'd5,
    FAULT      = 3'd6
  } state_t;

  localparam int unsigned NICKEL = 5;
  localparam int unsigned DIME   = 10;

  // The vending FSM only ever owes one nickel of change.
  function automatic logic [1:0] fsm_r_to_coins(input logic fsm_r);
    return fsm_r ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a rising-edge detector; pulse is one cycle wide.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    prev_d = sync_q[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Turns a one-cycle vend request into timed motor drive, drop confirmation with
// timeout, and nickel-return solenoid pulses.
//
// state      | meaning
// IDLE       | waiting for serve
// MOTOR      | product motor energised for MOTOR_CYCLES
// WAIT_DROP  | motor off, waiting for drop sensor or timeout
// CHANGE_ON  | solenoid energised for one nickel
// CHANGE_GAP | solenoid rest between nickels
// DONE       | one-cycle completion
// FAULT      | drop never seen; held until fault_clr
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES = 8,
  parameter int DROP_TIMEOUT = 64,
  parameter int SOL_CYCLES   = 4,
  parameter int SOL_GAP      = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serve,
  input  logic [1:0] coins_due,
  input  logic       drop_sensor,
  input  logic       fault_clr,
  output logic       motor_on,
  output logic       coin_sol,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       req_dropped
);

  localparam logic [CNT_W-1:0] MOTOR_LD = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] DROP_LD  = CNT_W'(DROP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SOL_LD   = CNT_W'(SOL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(SOL_GAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       coins_q, coins_d;
  logic             drop_seen_q, drop_seen_d;
  logic             motor_on_q, motor_on_d;
  logic             coin_sol_q, coin_sol_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             req_dropped_q, req_dropped_d;
  logic             drop_edge;
  logic             seen;

  sync_edge_det u_drop_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (drop_sensor),
    .pulse (drop_edge)
  );

  // An edge in the current cycle counts the same as one already remembered.
  assign seen = drop_seen_q | drop_edge;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    coins_d     = coins_q;
    drop_seen_d = drop_seen_q;
    case (state_q)
      IDLE: begin
        if (serve) begin
          coins_d     = coins_due;
          cnt_d       = MOTOR_LD;
          drop_seen_d = 1'b0;
          state_d     = MOTOR;
        end
      end
      MOTOR: begin
        if (drop_edge) drop_seen_d = 1'b1;
        if (cnt_q == '0) begin
          if (seen) begin
            if (coins_q != 2'd0) begin
              cnt_d   = SOL_LD;
              state_d = CHANGE_ON;
            end else begin
              state_d = DONE;
            end
          end else begin
            cnt_d   = DROP_LD;
            state_d = WAIT_DROP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_DROP: begin
        if (drop_edge) drop_seen_d = 1'b1;
        if (seen) begin
          if (coins_q != 2'd0) begin
            cnt_d   = SOL_LD;
            state_d = CHANGE_ON;
          end else begin
            state_d = DONE;
          end
        end else if (cnt_q == '0) begin
          coins_d = 2'd0;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CHANGE_ON: begin
        if (cnt_q == '0) begin
          coins_d = coins_q - 2'd1;
          if (coins_q == 2'd1) begin
            state_d = DONE;
          end else begin
            cnt_d   = GAP_LD;
            state_d = CHANGE_GAP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CHANGE_GAP: begin
        if (cnt_q == '0) begin
          cnt_d   = SOL_LD;
          state_d = CHANGE_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      FAULT: begin
        if (fault_clr) state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        coins_d     = 2'd0;
        drop_seen_d = 1'b0;
      end
    endcase

    // Outputs are decoded from the next state so they move on the same edge.
    motor_on_d    = (state_d == MOTOR);
    coin_sol_d    = (state_d == CHANGE_ON);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    fault_d       = (state_d == FAULT);
    req_dropped_d = serve && (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      coins_q       <= 2'd0;
      drop_seen_q   <= 1'b0;
      motor_on_q    <= 1'b0;
      coin_sol_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      req_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      coins_q       <= coins_d;
      drop_seen_q   <= drop_seen_d;
      motor_on_q    <= motor_on_d;
      coin_sol_q    <= coin_sol_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
      req_dropped_q <= req_dropped_d;
    end
  end

  assign motor_on    = motor_on_q;
  assign coin_sol    = coin_sol_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign req_dropped = req_dropped_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scenario bench for vend_dispense_ctrl: expected output vectors are queued per
// scenario from the timing rules and popped one per clock edge.
module tb_vend_dispense_ctrl;

  // Vector layout: {motor_on, coin_sol, busy, done, fault, req_dropped}
  localparam logic [5:0] V_0 = 6'b000000;
  localparam logic [5:0] V_M = 6'b101000;
  localparam logic [5:0] V_C = 6'b011000;
  localparam logic [5:0] V_B = 6'b001000;
  localparam logic [5:0] V_D = 6'b001100;
  localparam logic [5:0] V_F = 6'b001010;
  localparam logic [5:0] V_R = 6'b000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serve = 1'b0;
  logic [1:0] coins_due = 2'd0;
  logic       drop_sensor = 1'b0;
  logic       fault_clr = 1'b0;
  logic       motor_on, coin_sol, busy, done, fault, req_dropped;
  logic [5:0] obs;
  logic [5:0] exp_v;
  logic [5:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  assign obs = {motor_on, coin_sol, busy, done, fault, req_dropped};

  vend_dispense_ctrl #(
    .MOTOR_CYCLES (8),
    .DROP_TIMEOUT (64),
    .SOL_CYCLES   (4),
    .SOL_GAP      (4),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .serve       (serve),
    .coins_due   (coins_due),
    .drop_sensor (drop_sensor),
    .fault_clr   (fault_clr),
    .motor_on    (motor_on),
    .coin_sol    (coin_sol),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .req_dropped (req_dropped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    coins_due = 2'd3;
    repeat (2) tick();
    n_vec++;
    if (obs !== V_0) begin
      n_err++;
      $display("FAIL reset_outputs obs=%b exp=%b", obs, V_0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(V_0);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL idle_coins_ignored i=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    coins_due = 2'd0;
  endtask

  task automatic test_drop_after_motor();
    int motor_cnt = 0;
    for (int i = 0; i < 24; i++)
      exp_q.push_back(i < 8 ? V_M : i < 20 ? V_B : i == 20 ? V_D : V_0);
    for (int i = 0; i < 24; i++) begin
      serve = (i == 0);
      coins_due = 2'd0;
      drop_sensor = (i >= 18 && i <= 20);
      tick();
      if (motor_on) motor_cnt++;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL drop_after_motor i=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    serve = 1'b0;
    drop_sensor = 1'b0;
    n_vec++;
    if (motor_cnt !== 8) begin
      n_err++;
      $display("FAIL motor_on_cycles got=%0d exp=8", motor_cnt);
    end
  endtask

  task automatic test_change_two_nickels();
    int   pulses = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 23; i++)
      exp_q.push_back(i < 8 ? V_M : i < 12 ? V_C : i < 16 ? V_B :
                      i < 20 ? V_C : i == 20 ? V_D : V_0);
    for (int i = 0; i < 23; i++) begin
      serve = (i == 0);
      coins_due = (i == 0) ? 2'd2 : 2'd0;
      drop_sensor = (i >= 1 && i <= 3);
      tick();
      if (coin_sol && !prev) pulses++;
      prev = coin_sol;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL change_two i=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    serve = 1'b0;
    drop_sensor = 1'b0;
    n_vec++;
    if (pulses !== 2) begin
      n_err++;
      $display("FAIL sol_pulse_count got=%0d exp=2", pulses);
    end
  endtask

  task automatic test_timeout_fault();
    for (int i = 0; i < 78; i++)
      exp_q.push_back(i < 8 ? V_M : i < 72 ? V_B : i == 74 ? (V_F | V_R) :
                      i < 76 ? V_F : V_0);
    for (int i = 0; i < 78; i++) begin
      serve = (i == 0 || i == 74);
      coins_due = 2'd2;
      fault_clr = (i == 76);
      tick();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL timeout_fault i=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    serve = 1'b0;
    fault_clr = 1'b0;
    coins_due = 2'd0;
  endtask

  task automatic test_busy_serve_dropped();
    for (int i = 0; i < 19; i++)
      exp_q.push_back(i < 8 ? ((i == 3 || i == 5) ? (V_M | V_R) : V_M) :
                      i < 12 ? V_B : i < 16 ? V_C : i == 16 ? V_D : V_0);
    for (int i = 0; i < 19; i++) begin
      serve = (i == 0 || i == 3 || i == 5);
      coins_due = (i == 0) ? 2'd1 : 2'd3;
      drop_sensor = (i >= 10 && i <= 11);
      tick();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL busy_serve i=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    serve = 1'b0;
    drop_sensor = 1'b0;
    coins_due = 2'd0;
  endtask

  task automatic test_reset_mid_change();
    for (int i = 0; i < 10; i++) exp_q.push_back(i < 8 ? V_M : V_C);
    for (int i = 0; i < 10; i++) begin
      serve = (i == 0);
      coins_due = 2'd3;
      drop_sensor = (i >= 1 && i <= 2);
      tick();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL pre_reset i=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    serve = 1'b0;
    coins_due = 2'd0;
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(V_0);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL async_reset obs=%b exp=%b", obs, exp_v);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) exp_q.push_back(i < 8 ? V_M : i == 8 ? V_D : V_0);
    for (int i = 0; i < 10; i++) begin
      serve = (i == 0);
      drop_sensor = (i >= 1 && i <= 2);
      tick();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL post_reset_vend i=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    serve = 1'b0;
    drop_sensor = 1'b0;
  endtask

  task automatic test_drop_at_timeout_boundary();
    for (int i = 0; i < 74; i++)
      exp_q.push_back(i < 8 ? V_M : i < 72 ? V_B : i == 72 ? V_D : V_0);
    for (int i = 0; i < 74; i++) begin
      serve = (i == 0);
      coins_due = 2'd0;
      drop_sensor = (i >= 70 && i <= 72);
      tick();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL timeout_boundary i=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    serve = 1'b0;
    drop_sensor = 1'b0;
  endtask

  initial begin
    test_reset();
    test_drop_after_motor();
    test_change_two_nickels();
    test_timeout_fault();
    test_busy_serve_dropped();
    test_reset_mid_change();
    test_drop_at_timeout_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
